// File: rtl/dac_interface.sv
// dac_interface
// Transmit path from the signal-generation logic to an external SDR parallel DAC.
// A small FIFO takes samples over a valid/ready stream. A two-state controller
// divides SYS_CLK into DAC_CLK and launches one sample per DAC_CLK period, on
// the falling edge. The DAC latches on the rising edge, so data is stable for
// half a period on either side of that edge.
// All logic runs on the rising edge of SYS_CLK.

module dac_interface #(
    parameter int                 DATA_W     = 10,
    parameter int                 CLK_DIV    = 4,     // even, >= 2
    parameter int                 FIFO_DEPTH = 4,     // power of two, >= 2
    parameter logic [DATA_W-1:0]  IDLE_CODE  = 10'h200
) (
    input  logic              SYS_CLK,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic [DATA_W-1:0] APP_DATA,
    input  logic              APP_DATA_VALID,
    output logic              APP_DATA_READY,
    output logic              UNDERRUN,
    output logic              DAC_CLK,
    output logic [DATA_W-1:0] DAC_D,
    output logic              DAC_DTR
);

    localparam int PH_W  = $clog2(CLK_DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;

    // Phase at which DAC_CLK falls and a sample is launched.
    localparam logic [PH_W-1:0] PH_STROBE = PH_W'(CLK_DIV / 2 - 1);
    // Last phase of a DAC_CLK period; the only point where a stop is honoured.
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLK_DIV - 1);
    // First phase of the low half of DAC_CLK.
    localparam logic [PH_W-1:0] PH_HALF   = PH_W'(CLK_DIV / 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    assign full           = (count == CNT_FULL);
    assign empty          = (count == '0);
    assign push           = APP_DATA_VALID && !full;
    assign head           = mem[rd_ptr];
    assign APP_DATA_READY = !full;

    // Sample storage: written on every accepted sample.
    // NOTE: the storage array has no reset; the count/pointers alone decide
    // which entries are valid, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge SYS_CLK) begin
        if (push) begin
            mem[wr_ptr] <= APP_DATA;
        end
    end

    // FIFO bookkeeping: pointers wrap naturally because depth is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // DAC clock / launch controller
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            state_n;
    logic [PH_W-1:0]   phase_q;
    logic [PH_W-1:0]   phase_n;
    logic              dac_clk_q;
    logic              dac_clk_n;
    logic [DATA_W-1:0] dac_d_q;
    logic [DATA_W-1:0] dac_d_n;
    logic              dac_dtr_q;
    logic              dac_dtr_n;
    logic              underrun_q;
    logic              underrun_n;

    // Controller and output registers: all pin-facing outputs come straight from flops.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            dac_clk_q  <= 1'b0;
            dac_d_q    <= IDLE_CODE;
            dac_dtr_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            phase_q    <= phase_n;
            dac_clk_q  <= dac_clk_n;
            dac_d_q    <= dac_d_n;
            dac_dtr_q  <= dac_dtr_n;
            underrun_q <= underrun_n;
        end
    end

    // Next state, phase and pin values; also decides when the FIFO is popped.
    // NOTE: every signal gets a default before the case statement so that no
    // path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_n    = state_q;
        phase_n    = phase_q;
        dac_clk_n  = dac_clk_q;
        dac_d_n    = dac_d_q;
        dac_dtr_n  = dac_dtr_q;
        underrun_n = underrun_q;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                phase_n   = '0;
                dac_clk_n = 1'b0;
                dac_d_n   = IDLE_CODE;
                dac_dtr_n = 1'b0;
                if (ENABLE) begin
                    // DAC_CLK rises on the same edge that starts the run.
                    state_n   = ST_RUN;
                    dac_clk_n = 1'b1;
                end
            end

            ST_RUN: begin
                if (phase_q == PH_LAST && !ENABLE) begin
                    // Stop only at the end of a full period, so the DAC never
                    // sees a runt clock pulse.
                    state_n    = ST_IDLE;
                    phase_n    = '0;
                    dac_clk_n  = 1'b0;
                    dac_d_n    = IDLE_CODE;
                    dac_dtr_n  = 1'b0;
                    underrun_n = 1'b0;
                end else begin
                    phase_n   = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
                    dac_clk_n = (phase_n < PH_HALF);
                    if (phase_q == PH_STROBE) begin
                        // The empty flag is registered, so a sample written on
                        // this same edge is not visible yet and goes out at
                        // the next strobe.
                        if (!empty) begin
                            pop       = 1'b1;
                            dac_d_n   = head;
                            dac_dtr_n = 1'b1;
                        end else begin
                            dac_d_n    = IDLE_CODE;
                            dac_dtr_n  = 1'b0;
                            underrun_n = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign DAC_CLK  = dac_clk_q;
    assign DAC_D    = dac_d_q;
    assign DAC_DTR  = dac_dtr_q;
    assign UNDERRUN = underrun_q;

endmodule

// File: doc/dac_interface.md
# dac_interface

Parallel-DAC transmit interface for the acoustic carrier board: accepts samples from the application over a valid/ready stream, buffers them in a small FIFO, and drives an external SDR parallel DAC with a divided sample clock, data bus and data-valid strobe. It is the outbound counterpart of the ADC capture path. It sits between the signal-generation logic and the DAC pins, entirely in the SYS_CLK domain.

## Interface
- DATA_W, 10: sample width.
- CLK_DIV, 4: SYS_CLK cycles per DAC_CLK period; even, ≥2.
- FIFO_DEPTH, 4: sample buffer depth; power of two, ≥2.
- IDLE_CODE, 10'h200: code driven when no valid sample (midscale).

- SYS_CLK  in  1  single clock; all logic rising-edge.
- RESET_N  in  1  reset, asynchronous and active-low.
- ENABLE  in  1  run request; level-sensitive.
- APP_DATA  in  DATA_W  sample from application.
- APP_DATA_VALID  in  1  APP_DATA valid.
- APP_DATA_READY  out  1  FIFO can accept; = !full.
- UNDERRUN  out  1  sticky: a sample slot found the FIFO empty.
- DAC_CLK  out  1  registered DAC sample clock.
- DAC_D  out  DATA_W  registered DAC data.
- DAC_DTR  out  1  registered; high while DAC_D holds a real sample.

## Operation
- Reset (async assert): state IDLE, phase=0, FIFO empty, DAC_CLK=0, DAC_D=IDLE_CODE, DAC_DTR=0, UNDERRUN=0, APP_DATA_READY=1 once FIFO logic out of reset.
- FIFO write on APP_DATA_VALID & APP_DATA_READY, in any state (prefill allowed in IDLE). No write when full; APP_DATA must be held by source (standard valid/ready).
- States:
  - IDLE: DAC_CLK=0, DAC_D=IDLE_CODE, DAC_DTR=0, phase held 0. ENABLE sampled high → RUN; same edge sets DAC_CLK=1, phase=0.
  - RUN: phase increments every cycle, wraps CLK_DIV-1→0. DAC_CLK register = 1 for phase 0..CLK_DIV/2-1, 0 otherwise (set on the edge that moves phase).
- Strobe: the edge where registered phase == CLK_DIV/2-1 (DAC_CLK falls). At strobe:
  - FIFO non-empty: pop; DAC_D ← head; DAC_DTR ← 1.
  - FIFO empty: DAC_D ← IDLE_CODE; DAC_DTR ← 0; UNDERRUN ← 1.
- No write-to-read bypass: a write on the strobe cycle into an empty FIFO still counts as underrun; the sample goes out at the next strobe.
- Stop: in RUN with ENABLE low at the edge where phase == CLK_DIV-1 → IDLE (DAC_CLK stays 0, DAC_D ← IDLE_CODE, DAC_DTR ← 0, UNDERRUN ← 0). ENABLE low at any other phase is ignored until that point; no runt DAC_CLK pulses. ENABLE high again before that edge cancels the stop.
- FIFO contents retained across RUN→IDLE.
- UNDERRUN clears only on reset or IDLE entry.

## Timing
- DAC_CLK period = CLK_DIV SYS_CLK cycles, 50% duty.
- DAC_D/DAC_DTR change only with the DAC_CLK falling edge; stable CLK_DIV/2 cycles before and after each DAC_CLK rising edge (DAC latches on rising edge).
- Latency, ENABLE sampled at edge t0 (CLK_DIV=4): DAC_CLK=1 from t0, first strobe at t2 (DAC_CLK=0, DAC_D=FIFO head), first rising edge with data at t4.
- Write-to-DAC_D: ≥1 cycle; pops at one per CLK_DIV cycles.
- APP_DATA_READY deasserts the cycle after the write that fills the FIFO; reasserts the cycle after a pop from full.

## Test plan
- Reset mid-RUN with FIFO holding 2 samples → immediately DAC_CLK=0, DAC_D=0x200, DAC_DTR=0, UNDERRUN=0, READY=1; FIFO empty after release.
- Prefill 0x001..0x004 in IDLE, then ENABLE=1 (CLK_DIV=4) → READY low after 4th write; DAC_D = 0x001,0x002,0x003,0x004 at strobes 4 cycles apart, DAC_DTR=1, each stable across a DAC_CLK rise.
- Continue RUN with no further writes → 5th strobe drives 0x200, DTR=0, UNDERRUN=1 and stays 1; a later write 0x155 appears at the next strobe with DTR=1, UNDERRUN still 1.
- Source holds VALID with ramp 0x000.. while FIFO full → READY toggles with pops, DAC_D sequence contiguous, no lost or duplicated samples over 64 samples.
- Drop ENABLE at phase 1 → DAC_CLK completes its period; IDLE entered at phase 3 edge, UNDERRUN cleared, remaining FIFO samples output in order after re-enable.
- Write into empty FIFO exactly on strobe cycle → that strobe underruns (0x200, DTR=0); sample appears next strobe.
